// File: rtl/prog_loader_ctrl.sv
// Program RAM loader sequencer: holds the CPU in reset while a byte stream is written from address 0.
// Optional running byte checksum output enabled with `define LOADER_CKSUM_EN.
module prog_loader_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  output logic              cpu_reset_n_o,
  output logic [ADDR_W-1:0] ram_r_addr_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_w_addr_o,
  output logic [DATA_W-1:0] ram_w_data_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   load_cnt_o,
  output logic              err_ovf_o
`ifdef LOADER_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum_o
`endif
);

  localparam int DLY_W = (RELEASE_DLY < 2) ? 1 : $clog2(RELEASE_DLY);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(RELEASE_DLY - 1);
  localparam logic [ADDR_W:0]  CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e              state_q;
  logic [DLY_W-1:0]    dly_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     load_cnt_q;
  logic                err_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                beat;
  logic                ptr_at_max;
  logic [ADDR_W-1:0]   ptr_d;
  logic [ADDR_W:0]     load_cnt_d;

  assign beat       = ld_valid_i && (state_q == ST_LOAD);
  assign ptr_at_max = &ptr_q;
  // Pointer parks at the top address; overflow leaves LOAD on that same beat.
  assign ptr_d      = ptr_at_max ? ptr_q : ptr_q + ADDR_W'(1);
  assign load_cnt_d = (load_cnt_q == CNT_MAX) ? load_cnt_q : load_cnt_q + (ADDR_W+1)'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_HOLD;
      dly_q      <= DLY_INIT;
      ptr_q      <= '0;
      load_cnt_q <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (ld_start_i) begin
            state_q    <= ST_LOAD;
            ptr_q      <= '0;
            load_cnt_q <= '0;
            err_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            we_q       <= 1'b1;
            waddr_q    <= ptr_q;
            wdata_q    <= ld_data_i;
            ptr_q      <= ptr_d;
            load_cnt_q <= load_cnt_d;
            if (ld_last_i) begin
              state_q <= ST_HOLD;
              dly_q   <= DLY_INIT;
            end else if (ptr_at_max) begin
              err_q   <= 1'b1;
              state_q <= ST_HOLD;
              dly_q   <= DLY_INIT;
            end
          end
        end
        ST_HOLD: begin
          if (dly_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end
        default: begin
          state_q <= ST_HOLD;
          dly_q   <= DLY_INIT;
        end
      endcase
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cksum_q <= '0;
    end else if (state_q == ST_RUN && ld_start_i) begin
      cksum_q <= '0;
    end else if (beat) begin
      cksum_q <= cksum_q + ld_data_i;
    end
  end

  assign cksum_o = cksum_q;
`endif

  assign cpu_reset_n_o = (state_q == ST_RUN);
  assign ld_ready_o    = (state_q == ST_LOAD);
  assign busy_o        = (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign ram_r_addr_o  = (state_q == ST_RUN) ? cpu_adr_i : '0;
  assign ram_we_o      = we_q;
  assign ram_w_addr_o  = waddr_q;
  assign ram_w_data_o  = wdata_q;
  assign load_cnt_o    = load_cnt_q;
  assign err_ovf_o     = err_q;

endmodule
